// File: rtl/bram_stream_pkg.sv
// Shared types and helpers for the BRAM stream controller.
package bram_stream_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  // Requested burst length saturated to the RAM depth.
  function automatic int unsigned clamp_len(input int unsigned req, input int unsigned depth);
    return (req > depth) ? depth : req;
  endfunction

endpackage

// File: rtl/bram_stream_ctrl_if.sv
// Control, stream and RAM-initiator signals of bram_stream_ctrl.
interface bram_stream_ctrl_if #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 24
);
  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam int LEN_W  = $clog2(MEM_SIZE + 1);

  logic                 start_wr;
  logic                 start_rd;
  logic [LEN_W-1:0]     len;
  logic                 busy;
  logic                 done;
  logic [MEM_WIDTH-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic [MEM_WIDTH-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [MEM_WIDTH-1:0] ram_di;
  logic [MEM_WIDTH-1:0] ram_dout;

  modport master (
    input  start_wr, start_rd, len, din, din_valid, dout_ready, ram_dout,
    output busy, done, din_ready, dout, dout_valid, ram_en, ram_we, ram_addr, ram_di
  );

  modport slave (
    output start_wr, start_rd, len, din, din_valid, dout_ready, ram_dout,
    input  busy, done, din_ready, dout, dout_valid, ram_en, ram_we, ram_addr, ram_di
  );
endinterface

// File: rtl/single_port_ram.sv
// Single-port RAM with registered read data (one-cycle read latency).
module single_port_ram #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 24
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic                        we,
  input  logic [$clog2(MEM_SIZE)-1:0] addr,
  input  logic [MEM_WIDTH-1:0]        di,
  output logic [MEM_WIDTH-1:0]        dout
);
  logic [MEM_WIDTH-1:0] mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= di;
      dout <= mem[addr];
    end
  end
endmodule

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO; head word is presented combinationally on dout.
module stream_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wp_q, wp_d, rp_q, rp_d;
  logic [1:0]        occ_q, occ_d;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d  = wp_q ^ push;
    rp_d  = rp_q ^ pop;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      occ_q <= occ_d;
    end
  end

  assign dout = mem_q[rp_q];
  assign occ  = occ_q;
endmodule

// File: rtl/bram_stream_ctrl.sv
// Turns a valid/ready stream into sequential BRAM write bursts and BRAM read
// bursts back into a valid/ready stream, hiding the one-cycle read latency.
module bram_stream_ctrl
  import bram_stream_pkg::*;
#(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 24
) (
  input logic               clk,
  input logic               rst_n,
  bram_stream_ctrl_if.master bus
);
  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam int LEN_W  = $clog2(MEM_SIZE + 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;     // beats accepted (WR) or reads issued (RD)
  logic [LEN_W-1:0]   pops_q, pops_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               inflight_q, inflight_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   len_clamped;
  logic [1:0]         occ;
  logic               fifo_vld, pop;
  logic [2:0]         level;

  assign len_clamped = LEN_W'(clamp_len(32'(bus.len), 32'(MEM_SIZE)));
  assign fifo_vld    = (occ != 2'd0);
  assign pop         = fifo_vld & bus.dout_ready;
  assign level       = {1'b0, occ} + {2'b0, inflight_q};

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    pops_d       = pops_q;
    len_d        = len_q;
    inflight_d   = 1'b0;
    done_d       = 1'b0;
    bus.ram_en   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = ptr_q;
    bus.ram_di   = bus.din;
    bus.din_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_wr || bus.start_rd) begin
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = len_clamped;
            ptr_d   = '0;
            cnt_d   = '0;
            pops_d  = '0;
            state_d = bus.start_wr ? WR : RD;
          end
        end
      end
      WR: begin
        bus.din_ready = 1'b1;
        if (bus.din_valid) begin
          bus.ram_en = 1'b1;
          bus.ram_we = 1'b1;
          ptr_d      = ptr_q + ADDR_W'(1);
          cnt_d      = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RD: begin
        // Only issue when the word will have a FIFO slot on arrival.
        if ((cnt_q < len_q) && (level < (3'd2 + {2'b0, pop}))) begin
          bus.ram_en = 1'b1;
          ptr_d      = ptr_q + ADDR_W'(1);
          cnt_d      = cnt_q + LEN_W'(1);
          inflight_d = 1'b1;
        end
        if (pop) begin
          pops_d = pops_q + LEN_W'(1);
          if (pops_q == len_q - LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      pops_q     <= '0;
      len_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      pops_q     <= pops_d;
      len_q      <= len_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  stream_fifo2 #(.W(MEM_WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .pop   (pop),
    .din   (bus.ram_dout),
    .dout  (bus.dout),
    .occ   (occ)
  );

  assign bus.dout_valid = fifo_vld;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Directed bench: bram_stream_ctrl driving a single_port_ram.
module tb_bram_stream_ctrl;
  localparam int MW = 32;
  localparam int MS = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_stream_ctrl_if #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) bus ();

  bram_stream_ctrl #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  single_port_ram #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) ram (
    .clk  (clk),
    .en   (bus.ram_en),
    .we   (bus.ram_we),
    .addr (bus.ram_addr),
    .di   (bus.ram_di),
    .dout (bus.ram_dout)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Bus monitor: access counts, received words, and an occupancy model of
  // FIFO + in-flight reads rebuilt from observed RAM and stream activity.
  int          en_cnt = 0, we_cnt = 0, viol = 0, rx_n = 0, m_occ = 0, m_infl = 0;
  logic [31:0] rx_mem [0:255];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_occ  <= 0;
      m_infl <= 0;
    end else begin
      if (bus.ram_en && !bus.ram_we &&
          (m_occ + m_infl - int'(bus.dout_valid & bus.dout_ready)) >= 2)
        viol <= viol + 1;
      m_occ  <= m_occ + m_infl - int'(bus.dout_valid & bus.dout_ready);
      m_infl <= int'(bus.ram_en & ~bus.ram_we);
      en_cnt <= en_cnt + int'(bus.ram_en);
      we_cnt <= we_cnt + int'(bus.ram_en & bus.ram_we);
      if (bus.dout_valid && bus.dout_ready && rx_n < 256) begin
        rx_mem[rx_n] <= bus.dout;
        rx_n         <= rx_n + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!bus.done && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.done), 32'd1);
  endtask

  initial begin
    int en0, we0, rx0, c;
    bus.start_wr = 0; bus.start_rd = 0; bus.len = '0;
    bus.din = '0; bus.din_valid = 0; bus.dout_ready = 0;

    // Reset state
    step(); step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_dvalid", 32'(bus.dout_valid), 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_ram_en", 32'(bus.ram_en), 0);
    chk("rst_din_ready", 32'(bus.din_ready), 0);
    rst_n = 1'b1;
    step();

    // Write burst of 24, din_valid held high
    bus.start_wr = 1; bus.len = 5'd24; bus.din_valid = 1; bus.din = 32'h1000;
    step();
    bus.start_wr = 0;
    for (int i = 0; i < 24; i++) begin
      bus.din = 32'h1000 + 32'(i);
      #1;
      chk("wr_en_we", {30'd0, bus.ram_en, bus.ram_we}, 32'd3);
      chk("wr_addr", 32'(bus.ram_addr), 32'(i));
      chk("wr_di", bus.ram_di, 32'h1000 + 32'(i));
      step();
    end
    chk("wr_done", 32'(bus.done), 1);
    chk("wr_busy_at_done", 32'(bus.busy), 0);
    bus.din_valid = 0;
    step();
    chk("wr_done_pulse", 32'(bus.done), 0);

    // Read burst of 24, dout_ready held high
    en0 = en_cnt; rx0 = rx_n;
    bus.start_rd = 1; bus.len = 5'd24; bus.dout_ready = 1;
    step();
    bus.start_rd = 0;
    chk("rd_c1_en", {30'd0, bus.ram_en, bus.ram_we}, 32'd2);
    chk("rd_c1_addr", 32'(bus.ram_addr), 0);
    chk("rd_c1_dvalid", 32'(bus.dout_valid), 0);
    step();
    chk("rd_c2_dvalid", 32'(bus.dout_valid), 0);
    step();
    for (int k = 0; k < 24; k++) begin
      chk("rd_dvalid", 32'(bus.dout_valid), 1);
      chk("rd_dout", bus.dout, 32'h1000 + 32'(k));
      step();
    end
    chk("rd_done", 32'(bus.done), 1);
    chk("rd_busy_at_done", 32'(bus.busy), 0);
    chk("rd_en_count", 32'(en_cnt - en0), 24);
    chk("rd_rx_count", 32'(rx_n - rx0), 24);

    // Read with dout_ready pattern 1,0,0,1,0,0...
    en0 = en_cnt; rx0 = rx_n;
    bus.start_rd = 1; bus.len = 5'd24; bus.dout_ready = 1;
    step();
    bus.start_rd = 0;
    c = 1;
    while (!bus.done && c < 200) begin
      bus.dout_ready = (c % 3 == 0);
      step();
      c++;
    end
    chk("bp_done", 32'(bus.done), 1);
    chk("bp_rx_count", 32'(rx_n - rx0), 24);
    for (int k = 0; k < 24; k++)
      chk("bp_data", rx_mem[rx0 + k], 32'h1000 + 32'(k));
    chk("bp_en_count", 32'(en_cnt - en0), 24);
    chk("bp_no_overissue", 32'(viol), 0);
    bus.dout_ready = 1;
    step();

    // len = 0: immediate done, no RAM access
    en0 = en_cnt;
    bus.start_wr = 1; bus.len = 5'd0;
    step();
    bus.start_wr = 0;
    chk("len0_wr_done", 32'(bus.done), 1);
    chk("len0_wr_busy", 32'(bus.busy), 0);
    step();
    chk("len0_done_pulse", 32'(bus.done), 0);
    bus.start_rd = 1;
    step();
    bus.start_rd = 0;
    chk("len0_rd_done", 32'(bus.done), 1);
    step();
    chk("len0_en_count", 32'(en_cnt - en0), 0);

    // len = 30 clamps to 24: write same data back, then read
    we0 = we_cnt;
    bus.start_wr = 1; bus.len = 5'd30; bus.din_valid = 1; bus.din = 32'h1000;
    step();
    bus.start_wr = 0;
    c = 1;
    while (!bus.done && c < 100) begin
      bus.din = 32'h1000 + 32'(c - 1);
      step();
      c++;
    end
    bus.din_valid = 0;
    chk("len30_wr_done", 32'(bus.done), 1);
    chk("len30_wr_count", 32'(we_cnt - we0), 24);
    en0 = en_cnt; rx0 = rx_n;
    bus.start_rd = 1; bus.len = 5'd30;
    step();
    bus.start_rd = 0;
    wait_done(100, "len30_rd_done");
    chk("len30_rd_count", 32'(en_cnt - en0), 24);
    chk("len30_rx_count", 32'(rx_n - rx0), 24);
    chk("len30_first", rx_mem[rx0], 32'h1000);
    chk("len30_last", rx_mem[rx0 + 23], 32'h1017);
    step();

    // start_wr + start_rd together: write wins; start_rd during WR ignored
    en0 = en_cnt; we0 = we_cnt;
    bus.start_wr = 1; bus.start_rd = 1; bus.len = 5'd2;
    bus.din_valid = 1; bus.din = 32'h1000;
    step();
    bus.start_wr = 0;
    chk("both_c1_we", {30'd0, bus.ram_en, bus.ram_we}, 32'd3);
    step();
    bus.din = 32'h1001;
    #1;
    chk("both_c2_addr", 32'(bus.ram_addr), 1);
    step();
    bus.start_rd = 0; bus.din_valid = 0;
    chk("both_done", 32'(bus.done), 1);
    step(); step(); step();
    chk("both_busy", 32'(bus.busy), 0);
    chk("both_writes", 32'(we_cnt - we0), 2);
    chk("both_no_reads", 32'((en_cnt - en0) - (we_cnt - we0)), 0);

    // Reset mid-read after 5 pops, then a fresh read of 2
    rx0 = rx_n;
    bus.start_rd = 1; bus.len = 5'd24; bus.dout_ready = 1;
    step();
    bus.start_rd = 0;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pops", 32'(rx_n - rx0), 5);
    chk("mid_rst_dvalid", 32'(bus.dout_valid), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_dout", bus.dout, 0);
    step();
    rst_n = 1'b1;
    rx0 = rx_n;
    bus.start_rd = 1; bus.len = 5'd2;
    step();
    bus.start_rd = 0;
    wait_done(20, "post_rst_done");
    chk("post_rst_count", 32'(rx_n - rx0), 2);
    chk("post_rst_w0", rx_mem[rx0], 32'h1000);
    chk("post_rst_w1", rx_mem[rx0 + 1], 32'h1001);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_stream_ctrl.md
# bram_stream_ctrl

Stream-side controller that drives a single-port BRAM (`single_port_ram` protocol: `en`, `we`, `addr`, `di`, registered `dout`) as its initiator. It turns a valid/ready input stream into a burst of sequential RAM writes, and a burst of sequential RAM reads into a valid/ready output stream. It absorbs the RAM's one-cycle read latency and downstream backpressure. It sits between the NewHope coefficient pipelines and each coefficient buffer RAM.

## Interface
- `MEM_WIDTH`, 32, data word width; must match the attached RAM.
- `MEM_SIZE`, 24, RAM depth in words; must match the attached RAM.
- `ADDR_W` (localparam) = `$clog2(MEM_SIZE)`; `LEN_W` (localparam) = `$clog2(MEM_SIZE+1)`.

- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_wr` in 1: start a write burst; sampled only in IDLE.
- `start_rd` in 1: start a read burst; sampled only in IDLE.
- `len` in LEN_W: burst length in words, latched together with the start.
- `busy` out 1: high while the state is not IDLE.
- `done` out 1: one-cycle pulse when a burst completes.
- `din` in MEM_WIDTH: write stream data.
- `din_valid` in 1: write stream valid.
- `din_ready` out 1: write stream ready.
- `dout` out MEM_WIDTH: read stream data.
- `dout_valid` out 1: read stream valid.
- `dout_ready` in 1: read stream ready.
- `ram_en` out 1: RAM enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_di` out MEM_WIDTH: RAM write data.
- `ram_dout` in MEM_WIDTH: RAM registered read data, valid the cycle after a read enable.

## Operation
- States: IDLE, WR, RD. Addresses always start at 0 and increment by 1.
- **Latching a burst in IDLE:**
  - `len` > MEM_SIZE is clamped to MEM_SIZE.
  - `len` = 0 gives no state change and no RAM access; `done` pulses next cycle.
- **Start priority:**
  - If `start_wr` and `start_rd` are both high, the write wins and `start_rd` is dropped.
  - Starts outside IDLE are ignored.
- **WR state:**
  - `din_ready` = 1.
  - Each beat with `din_valid & din_ready` drives `ram_en` = `ram_we` = 1, `ram_addr` = wr_ptr and `ram_di` = `din` combinationally in the same cycle.
  - The pointer and count increment on each accepted beat.
  - The last accepted beat (count = len-1) moves the state to IDLE.
- **RD state, read issue:**
  - `ram_en` = 1 and `ram_we` = 0 whenever `issued < len` and (fifo_occ + inflight − pop) < 2.
  - `pop` = `dout_valid & dout_ready`.
  - `inflight` is 1 in the cycle after a read issue.
- **RD state, data capture:**
  - `ram_dout` is pushed into a 2-entry output FIFO in the cycle when `inflight` = 1.
  - The FIFO head drives `dout`/`dout_valid`.
  - The state returns to IDLE after the len-th pop.
- **Outside a burst:** `ram_en`, `ram_we` and `din_ready` are 0 outside WR/RD activity; `ram_addr` and `ram_di` are don't-care when `ram_en` = 0.
- **Stream rules:** `dout` is stable while `dout_valid & !dout_ready`. `dout_valid` never drops without a pop.
- **Reset:** asynchronous assert at any time, including mid-burst.
  - State → IDLE, pointers and counts → 0, FIFO flushed.
  - `busy`, `done` and `dout_valid` = 0; `dout` = 0.
  - No partial-burst resumption.

## Timing
- Write: a beat accepted in cycle t is in RAM after the edge ending t, at 1 word/cycle max.
- `start_rd` sampled at the edge ending cycle 0 gives: RD and first `ram_en` in cycle 1, `ram_dout` valid in cycle 2, FIFO push at the edge ending cycle 2, `dout_valid` in cycle 3.
- Sustained throughput is 1 word/cycle with `dout_ready` held high.
- `done` is registered and high in the cycle after the final handshake (last write beat, or last pop). `busy` is 0 in that same cycle.
- A new start is accepted in the cycle `done` is high.

## Structure
- Shared package `bram_stream_pkg`:
  - `state_t` enum {IDLE, WR, RD};
  - helper function computing LEN_W clamping.
- Sub-module `stream_fifo2`: 2-entry register FIFO.
  - Signals: push, pop, data, occ[1:0], async active-low reset.
  - Instantiated once for the read path.
- Testbench instantiates `bram_stream_ctrl` wired to `single_port_ram` with matching parameters.

## Test plan
- Write `len` = 24, data 0x1000+i, `din_valid` always high → 24 consecutive `ram_we` cycles at addr 0..23; `done` in cycle 25 after start.
- Read `len` = 24 after the above, `dout_ready` = 1 → `dout_valid` from cycle 3; words 0x1000..0x1017 on 24 consecutive cycles; `done` one cycle after the last.
- Read `len` = 24 with `dout_ready` toggling 1,0,0,1… → sequence still 0x1000..0x1017 with no loss or duplicate; `ram_en` never issued while the FIFO plus in-flight count is 2 with no pop.
- `len` = 0 and `len` = 30 → `len` = 0: `done` next cycle with zero `ram_en`; `len` = 30: exactly 24 accesses (clamped).
- `start_wr` and `start_rd` together → write burst only; then `start_rd` during WR is ignored (no read occurs).
- `rst_n` low for 1 cycle mid-read after 5 pops → `dout_valid`, `busy` and `done` = 0 immediately; a new read of `len` = 2 returns 0x1000, 0x1001.
